// File: rtl/mpu_refresh_scheduler.sv
// Sequencer in front of the MPU LCD write engine: panel power-up/down, frame, segment and
// auto-refresh write arbitration, completion counting and stuck-engine detection.
module mpu_refresh_scheduler #(
    parameter int                   HRES_WIDTH   = 9,
    parameter int                   PERIOD_WIDTH = 24,
    parameter int                   TMO_WIDTH    = 24,
    parameter logic [TMO_WIDTH-1:0] TMO_VAL      = 24'hFFFFFF,
    parameter logic [3:0]           ST_IDLE      = 4'd3,
    parameter logic [3:0]           ST_SLEEP     = 4'd6
) (
    input  logic                    i_sysclk,
    input  logic                    i_arstn,
    input  logic                    i_pwr_on_req,
    input  logic                    i_pwr_off_req,
    input  logic                    i_frame_req,
    input  logic                    i_seg_req,
    input  logic [HRES_WIDTH-1:0]   i_seg_len,
    input  logic                    i_auto_en,
    input  logic [PERIOD_WIDTH-1:0] i_period,
    input  logic [3:0]              i_mpu_state,
    input  logic                    i_mpu_init_done,
    output logic                    o_mpu_on,
    output logic                    o_mpu_off,
    output logic                    o_mpu_mode,
    output logic                    o_mpu_trigger,
    output logic [HRES_WIDTH-1:0]   o_mpu_pixel,
    output logic                    o_busy,
    output logic                    o_frame_done,
    output logic [15:0]             o_frame_cnt,
    output logic                    o_err,
    output logic [2:0]              o_dbg_state
);

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_PWRUP = 3'd1,
        S_READY = 3'd2,
        S_ISSUE = 3'd3,
        S_BUSY  = 3'd4,
        S_PWRDN = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic                    pend_frame_q, pend_frame_d;
    logic                    pend_seg_q, pend_seg_d;
    logic                    pend_off_q, pend_off_d;
    logic [HRES_WIDTH-1:0]   seg_len_q, seg_len_d;
    logic [PERIOD_WIDTH-1:0] period_q, period_d;
    logic [TMO_WIDTH-1:0]    tmo_q, tmo_d;
    logic                    on_d, off_d, mode_d, trig_d, busy_d, done_d, err_d;
    logic [HRES_WIDTH-1:0]   pix_d;
    logic [15:0]             cnt_d;
    logic                    powered, tick, waiting;

    assign o_dbg_state = state_q;

    always_ff @(posedge i_sysclk or negedge i_arstn) begin
        if (!i_arstn) begin
            state_q       <= S_OFF;
            pend_frame_q  <= 1'b0;
            pend_seg_q    <= 1'b0;
            pend_off_q    <= 1'b0;
            seg_len_q     <= '0;
            period_q      <= '0;
            tmo_q         <= '0;
            o_mpu_on      <= 1'b0;
            o_mpu_off     <= 1'b0;
            o_mpu_mode    <= 1'b0;
            o_mpu_trigger <= 1'b0;
            o_mpu_pixel   <= '0;
            o_busy        <= 1'b0;
            o_frame_done  <= 1'b0;
            o_frame_cnt   <= '0;
            o_err         <= 1'b0;
        end else begin
            state_q       <= state_d;
            pend_frame_q  <= pend_frame_d;
            pend_seg_q    <= pend_seg_d;
            pend_off_q    <= pend_off_d;
            seg_len_q     <= seg_len_d;
            period_q      <= period_d;
            tmo_q         <= tmo_d;
            o_mpu_on      <= on_d;
            o_mpu_off     <= off_d;
            o_mpu_mode    <= mode_d;
            o_mpu_trigger <= trig_d;
            o_mpu_pixel   <= pix_d;
            o_busy        <= busy_d;
            o_frame_done  <= done_d;
            o_frame_cnt   <= cnt_d;
            o_err         <= err_d;
        end
    end

    // Trigger handshake: o_mpu_trigger (with mode/pixel) is held until the engine leaves
    // ST_IDLE, which acknowledges the write; completion is the engine returning to ST_IDLE.
    always_comb begin
        state_d      = state_q;
        pend_frame_d = pend_frame_q;
        pend_seg_d   = pend_seg_q;
        pend_off_d   = pend_off_q;
        seg_len_d    = seg_len_q;
        period_d     = '0;
        tmo_d        = '0;
        on_d         = 1'b0;
        off_d        = 1'b0;
        mode_d       = o_mpu_mode;
        trig_d       = o_mpu_trigger;
        pix_d        = o_mpu_pixel;
        done_d       = 1'b0;
        cnt_d        = o_frame_cnt;
        err_d        = o_err;
        tick         = 1'b0;
        powered      = state_q inside {S_PWRUP, S_READY, S_ISSUE, S_BUSY};
        waiting      = state_q inside {S_PWRUP, S_ISSUE, S_BUSY, S_PWRDN};

        if (powered && i_auto_en) begin
            if (period_q == i_period) begin
                tick = 1'b1;
            end else begin
                period_d = period_q + 1'b1;
            end
        end

        if (powered) begin
            if (i_frame_req || tick) pend_frame_d = 1'b1;
            if (i_seg_req) begin
                pend_seg_d = 1'b1;
                seg_len_d  = i_seg_len;
            end
            if (i_pwr_off_req) pend_off_d = 1'b1;
        end

        case (state_q)
            S_OFF: begin
                pend_frame_d = 1'b0;
                pend_seg_d   = 1'b0;
                pend_off_d   = 1'b0;
                if (i_pwr_on_req) begin
                    on_d    = 1'b1;
                    err_d   = 1'b0;
                    state_d = S_PWRUP;
                end
            end
            S_PWRUP: begin
                if (i_mpu_init_done && i_mpu_state == ST_IDLE) begin
                    period_d = '0;
                    state_d  = S_READY;
                end
            end
            S_READY: begin
                // A request landing in the grant cycle merges into the granted write.
                if (pend_off_q) begin
                    off_d        = 1'b1;
                    pend_frame_d = 1'b0;
                    pend_seg_d   = 1'b0;
                    pend_off_d   = 1'b0;
                    state_d      = S_PWRDN;
                end else if (pend_frame_q) begin
                    mode_d       = 1'b0;
                    trig_d       = 1'b1;
                    pend_frame_d = 1'b0;
                    state_d      = S_ISSUE;
                end else if (pend_seg_q) begin
                    mode_d     = 1'b1;
                    pix_d      = seg_len_q;
                    trig_d     = 1'b1;
                    pend_seg_d = 1'b0;
                    state_d    = S_ISSUE;
                end else if (tick) begin
                    mode_d       = 1'b0;
                    trig_d       = 1'b1;
                    pend_frame_d = 1'b0;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (i_mpu_state != ST_IDLE) begin
                    trig_d  = 1'b0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (i_mpu_state == ST_IDLE) begin
                    done_d  = 1'b1;
                    cnt_d   = o_frame_cnt + 16'd1;
                    state_d = S_READY;
                end
            end
            S_PWRDN: begin
                if (i_mpu_state == ST_SLEEP) state_d = S_OFF;
            end
            default: state_d = S_OFF;
        endcase

        // A wait state that stays put for TMO_VAL cycles aborts to OFF with controls dropped.
        if (waiting && state_d == state_q) begin
            if (tmo_q == TMO_VAL - 1'b1) begin
                state_d = S_OFF;
                err_d   = 1'b1;
                on_d    = 1'b0;
                off_d   = 1'b0;
                mode_d  = 1'b0;
                trig_d  = 1'b0;
                pix_d   = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end

        busy_d = state_d inside {S_PWRUP, S_ISSUE, S_BUSY, S_PWRDN};
    end

endmodule

// File: tb/tb_mpu_refresh_scheduler.sv
// Directed bench for mpu_refresh_scheduler: reactive engine model, cycle-level reference
// model compared every cycle, and hand-computed checks on each scenario.
module tb_mpu_refresh_scheduler;

    localparam int TMO = 120;
    localparam int M_OFF = 0, M_PWRUP = 1, M_READY = 2, M_ISSUE = 3, M_BUSY = 4, M_PWRDN = 5;

    logic        clk = 1'b0, arstn = 1'b0;
    logic        pwr_on_req = 0, pwr_off_req = 0, frame_req = 0, seg_req = 0, auto_en = 0;
    logic [8:0]  seg_len = '0;
    logic [23:0] period = '0;
    logic [3:0]  mpu_state;
    logic        init_done;
    logic        o_mpu_on, o_mpu_off, o_mpu_mode, o_mpu_trigger, o_busy, o_frame_done, o_err;
    logic [8:0]  o_mpu_pixel;
    logic [15:0] o_frame_cnt;
    logic [2:0]  o_dbg_state;

    int checks = 0, failures = 0;

    mpu_refresh_scheduler #(
        .HRES_WIDTH(9), .PERIOD_WIDTH(24), .TMO_WIDTH(24),
        .TMO_VAL(24'd120), .ST_IDLE(4'd3), .ST_SLEEP(4'd6)
    ) dut (
        .i_sysclk(clk), .i_arstn(arstn),
        .i_pwr_on_req(pwr_on_req), .i_pwr_off_req(pwr_off_req),
        .i_frame_req(frame_req), .i_seg_req(seg_req), .i_seg_len(seg_len),
        .i_auto_en(auto_en), .i_period(period),
        .i_mpu_state(mpu_state), .i_mpu_init_done(init_done),
        .o_mpu_on(o_mpu_on), .o_mpu_off(o_mpu_off), .o_mpu_mode(o_mpu_mode),
        .o_mpu_trigger(o_mpu_trigger), .o_mpu_pixel(o_mpu_pixel), .o_busy(o_busy),
        .o_frame_done(o_frame_done), .o_frame_cnt(o_frame_cnt), .o_err(o_err),
        .o_dbg_state(o_dbg_state)
    );

    // clock / reset
    initial forever #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // engine model: reacts to on/off/trigger, drives state code and init-done
    int  init_len = 50, start_dly = 2, busy_len = 100;
    bit  stuck = 0;
    int  e_ph = 0, e_w = 0;
    initial begin
        mpu_state = 4'd0;
        init_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!arstn) begin
                mpu_state = 4'd0; init_done = 1'b0; e_ph = 0;
            end else if (o_mpu_on) begin
                mpu_state = 4'd0; init_done = 1'b0; e_ph = 1; e_w = init_len;
            end else begin
                case (e_ph)
                    1: begin e_w--; if (e_w == 0) begin mpu_state = 4'd3; init_done = 1'b1; e_ph = 2; end end
                    2: if (o_mpu_off) begin e_ph = 6; e_w = 3; end
                       else if (o_mpu_trigger) begin e_ph = 3; e_w = start_dly; end
                    3: begin e_w--; if (e_w == 0) begin mpu_state = 4'd4; e_ph = 4; end end
                    4: begin mpu_state = 4'd5; e_w = busy_len; e_ph = 5; end
                    5: if (!stuck) begin e_w--; if (e_w == 0) begin mpu_state = 4'd3; e_ph = 2; end end
                    6: begin e_w--; if (e_w == 0) begin mpu_state = 4'd6; init_done = 1'b0; e_ph = 0; end end
                    default: ;
                endcase
            end
        end
    end

    // reference model: what each output must be after every edge
    int          ms = M_OFF, m_per = 0, m_age = 0, n_st, n_per;
    logic        m_pf = 0, m_ps = 0, m_po = 0, m_on = 0, m_off = 0, m_mode = 0, m_trig = 0;
    logic        m_busy = 0, m_done = 0, m_err = 0;
    logic [8:0]  m_len = '0, m_pix = '0;
    logic [15:0] m_cnt = '0;
    logic        live, tick, n_pf, n_ps, n_po, n_on, n_off, n_mode, n_trig, n_done, n_err;
    logic [8:0]  n_len, n_pix;
    logic [15:0] n_cnt;
    initial forever begin
        @(posedge clk or negedge arstn);
        if (!arstn) begin
            ms = M_OFF; m_per = 0; m_age = 0; m_pf = 0; m_ps = 0; m_po = 0; m_len = '0;
            m_on = 0; m_off = 0; m_mode = 0; m_trig = 0; m_pix = '0; m_busy = 0; m_done = 0;
            m_cnt = '0; m_err = 0;
        end else begin
            live  = ms inside {M_PWRUP, M_READY, M_ISSUE, M_BUSY};
            tick  = live && auto_en && (m_per == int'(period));
            n_per = (live && auto_en && !tick) ? m_per + 1 : 0;
            n_pf  = m_pf | (live & (frame_req | tick));
            n_ps  = m_ps | (live & seg_req);
            n_len = (live && seg_req) ? seg_len : m_len;
            n_po  = m_po | (live & pwr_off_req);
            n_st = ms; n_on = 0; n_off = 0; n_done = 0;
            n_mode = m_mode; n_trig = m_trig; n_pix = m_pix; n_cnt = m_cnt; n_err = m_err;
            case (ms)
                M_OFF: begin
                    n_pf = 0; n_ps = 0; n_po = 0;
                    if (pwr_on_req) begin n_on = 1; n_err = 0; n_st = M_PWRUP; end
                end
                M_PWRUP: if (init_done && mpu_state == 4'd3) begin n_st = M_READY; n_per = 0; end
                M_READY: begin
                    if (m_po) begin
                        n_off = 1; n_st = M_PWRDN; n_pf = 0; n_ps = 0; n_po = 0;
                    end else if (m_pf || (!m_ps && tick)) begin
                        n_mode = 0; n_trig = 1; n_st = M_ISSUE; n_pf = 0;
                    end else if (m_ps) begin
                        n_mode = 1; n_pix = m_len; n_trig = 1; n_st = M_ISSUE; n_ps = 0;
                    end
                end
                M_ISSUE: if (mpu_state != 4'd3) begin n_trig = 0; n_st = M_BUSY; end
                M_BUSY: if (mpu_state == 4'd3) begin n_done = 1; n_cnt = m_cnt + 16'd1; n_st = M_READY; end
                M_PWRDN: if (mpu_state == 4'd6) n_st = M_OFF;
                default: ;
            endcase
            if (n_st != ms || ms == M_OFF || ms == M_READY) begin
                m_age = 0;
            end else if (m_age + 1 == TMO) begin
                m_age = 0; n_st = M_OFF; n_err = 1;
                n_on = 0; n_off = 0; n_mode = 0; n_trig = 0; n_pix = '0;
            end else begin
                m_age++;
            end
            ms = n_st; m_per = n_per; m_pf = n_pf; m_ps = n_ps; m_po = n_po; m_len = n_len;
            m_on = n_on; m_off = n_off; m_mode = n_mode; m_trig = n_trig; m_pix = n_pix;
            m_done = n_done; m_cnt = n_cnt; m_err = n_err;
            m_busy = n_st inside {M_PWRUP, M_ISSUE, M_BUSY, M_PWRDN};
        end
    end

    // per-cycle compare of every output against the model
    initial forever begin
        @(negedge clk);
        chk("cycle_outputs",
            {o_mpu_on, o_mpu_off, o_mpu_mode, o_mpu_trigger, o_mpu_pixel, o_busy, o_frame_done, o_frame_cnt, o_err},
            {m_on, m_off, m_mode, m_trig, m_pix, m_busy, m_done, m_cnt, m_err});
    end

    // observation window driven from the main sequence
    int         wcyc = 0, w_on, w_off, w_trig_hi, w_busy_hi, w_done, fall_cyc, err_cyc;
    int         rise_cyc[$];
    logic [9:0] rise_info[$];
    logic [9:0] exp_q[$];
    logic [9:0] got;
    logic       prev_trig = 0, prev_err = 0;

    task automatic clear_win();
        w_on = 0; w_off = 0; w_trig_hi = 0; w_busy_hi = 0; w_done = 0; fall_cyc = 0; err_cyc = 0;
        rise_cyc.delete(); rise_info.delete();
    endtask

    task automatic watch(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wcyc++;
            if (o_mpu_on) w_on++;
            if (o_mpu_off) w_off++;
            if (o_mpu_trigger) w_trig_hi++;
            if (o_busy) w_busy_hi++;
            if (o_frame_done) w_done++;
            if (o_mpu_trigger && !prev_trig) begin
                rise_cyc.push_back(wcyc);
                rise_info.push_back({o_mpu_mode, o_mpu_pixel});
            end
            if (!o_mpu_trigger && prev_trig) fall_cyc = wcyc;
            if (o_err && !prev_err) err_cyc = wcyc;
            prev_trig = o_mpu_trigger;
            prev_err  = o_err;
        end
    endtask

    initial begin
        // reset
        repeat (3) @(negedge clk);
        chk("reset_outs", {o_mpu_on, o_mpu_off, o_mpu_mode, o_mpu_trigger, o_mpu_pixel, o_busy,
                           o_frame_done, o_frame_cnt, o_err}, 32'd0);
        arstn = 1'b1;
        watch(2);

        // power-up: on for one cycle, busy for 51 cycles
        clear_win();
        pwr_on_req = 1; watch(1); pwr_on_req = 0;
        watch(69);
        chk("pwrup_on_cycles", w_on, 1);
        chk("pwrup_busy_cycles", w_busy_hi, 51);
        chk("pwrup_busy_after", o_busy, 0);

        // full frame
        clear_win();
        frame_req = 1; watch(1); frame_req = 0;
        watch(200);
        chk("frame_rises", rise_cyc.size(), 1);
        got = (rise_info.size() > 0) ? rise_info[0] : 10'h3ff;
        chk("frame_mode", got[9], 0);
        chk("frame_trig_hold", w_trig_hi, 3);
        chk("frame_done_pulses", w_done, 1);
        chk("frame_cnt_1", o_frame_cnt, 1);

        // segments: second request queued during the first write
        clear_win();
        exp_q.push_back({1'b1, 9'd39});
        exp_q.push_back({1'b1, 9'd79});
        seg_len = 9'd39; seg_req = 1; watch(1); seg_req = 0;
        watch(30);
        seg_len = 9'd79; seg_req = 1; watch(1); seg_req = 0;
        watch(300);
        chk("seg_rises", rise_cyc.size(), 2);
        while (exp_q.size() > 0) begin
            got = (rise_info.size() > 0) ? rise_info.pop_front() : 10'h000;
            chk("seg_mode_pixel", got, exp_q.pop_front());
        end
        chk("seg_done_pulses", w_done, 2);
        chk("seg_cnt_3", o_frame_cnt, 3);

        // auto refresh every 1000 cycles
        busy_len = 8;
        clear_win();
        period = 24'd999; auto_en = 1;
        watch(5050);
        chk("auto_rises", rise_cyc.size(), 5);
        for (int i = 1; i < rise_cyc.size(); i++) chk("auto_spacing", rise_cyc[i] - rise_cyc[i-1], 1000);
        chk("auto_cnt_8", o_frame_cnt, 8);
        auto_en = 0;
        clear_win();
        watch(2000);
        chk("auto_off_rises", rise_cyc.size(), 0);
        chk("auto_off_cnt", o_frame_cnt, 8);

        // pending frame + power-off during a write: write finishes, off wins, frame dropped
        busy_len = 100;
        frame_req = 1; watch(1); frame_req = 0;
        watch(30);
        clear_win();
        frame_req = 1; pwr_off_req = 1; watch(1); frame_req = 0; pwr_off_req = 0;
        watch(150);
        chk("pwrdn_off_pulses", w_off, 1);
        chk("pwrdn_no_new_write", rise_cyc.size(), 0);
        chk("pwrdn_done_pulses", w_done, 1);
        chk("pwrdn_cnt_9", o_frame_cnt, 9);
        chk("pwrdn_busy_after", o_busy, 0);
        clear_win();
        frame_req = 1; watch(1); frame_req = 0;
        watch(5);
        chk("off_drops_frame", rise_cyc.size(), 0);

        // stuck engine: timeout TMO cycles after BUSY entry
        pwr_on_req = 1; watch(1); pwr_on_req = 0;
        watch(60);
        stuck = 1;
        clear_win();
        frame_req = 1; watch(1); frame_req = 0;
        watch(200);
        chk("tmo_delay", err_cyc - fall_cyc, TMO);
        chk("tmo_err", o_err, 1);
        chk("tmo_ctrls_zero", {o_mpu_on, o_mpu_off, o_mpu_mode, o_mpu_trigger, o_mpu_pixel}, 0);
        chk("tmo_busy", o_busy, 0);

        // on and off together from OFF: on wins, error clears
        clear_win();
        pwr_on_req = 1; pwr_off_req = 1; watch(1); pwr_on_req = 0; pwr_off_req = 0;
        stuck = 0;
        watch(60);
        chk("err_cleared", o_err, 0);
        chk("on_wins_busy", o_busy, 0);
        clear_win();
        frame_req = 1; watch(1); frame_req = 0;
        watch(20);
        chk("on_wins_ready", rise_cyc.size(), 1);

        // async reset mid-write
        @(posedge clk);
        #3 arstn = 1'b0;
        #1 chk("reset_mid_write", {o_mpu_on, o_mpu_off, o_mpu_mode, o_mpu_trigger, o_mpu_pixel, o_busy,
                                   o_frame_done, o_frame_cnt, o_err}, 32'd0);
        watch(2);
        arstn = 1'b1;
        watch(3);
        chk("reset_cnt_cleared", o_frame_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
